// File: rtl/reg_file.sv
// CPU general-purpose register file: two combinational read ports with optional
// write-through bypass, one synchronous write port, and an unbypassed debug read port.
module reg_file #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter bit WRITE_THROUGH = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Index 0 has no storage; it is the hard-wired zero register.
    logic [DATA_W-1:0] regs_q [1:DEPTH-1];

    logic              wr_en;
    logic              byp1;
    logic              byp2;
    logic [DATA_W-1:0] stored1;
    logic [DATA_W-1:0] stored2;
    logic [DATA_W-1:0] stored_dbg;

    assign wr_en = !rst && we && (wa != '0);

    for (genvar g = 1; g < DEPTH; g++) begin : g_reg
        always_ff @(posedge clk) begin
            if (rst) begin
                regs_q[g] <= '0;
            end else if (wr_en && (wa == ADDR_W'(g))) begin
                regs_q[g] <= wd;
            end
        end
    end

    // Address-compare mux: address 0 falls through to the zero default.
    always_comb begin
        stored1    = '0;
        stored2    = '0;
        stored_dbg = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (ra1 == ADDR_W'(i)) stored1 = regs_q[i];
            if (ra2 == ADDR_W'(i)) stored2 = regs_q[i];
            if (dbg_addr == ADDR_W'(i)) stored_dbg = regs_q[i];
        end
    end

    // wr_en already excludes wa==0 and reset, so a bypass never overrides the zero rule.
    assign byp1 = WRITE_THROUGH && wr_en && (ra1 == wa);
    assign byp2 = WRITE_THROUGH && wr_en && (ra2 == wa);

    assign rd1      = byp1 ? wd : stored1;
    assign rd2      = byp2 ? wd : stored2;
    assign dbg_data = stored_dbg;

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: two instances (write-through on and off) share stimulus; a monitor
// compares all six read outputs against an expected queue each negative clock edge.
module tb_reg_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] wt_rd1, wt_rd2, wt_dbg;
    logic [DATA_W-1:0] nw_rd1, nw_rd2, nw_dbg;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] exp_q[$];
    int                tag_q[$];

    reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WRITE_THROUGH(1'b1)) u_wt (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .rd1(wt_rd1), .ra2(ra2), .rd2(wt_rd2),
        .dbg_addr(dbg_addr), .dbg_data(wt_dbg)
    );

    reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WRITE_THROUGH(1'b0)) u_nw (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .rd1(nw_rd1), .ra2(ra2), .rd2(nw_rd2),
        .dbg_addr(dbg_addr), .dbg_data(nw_dbg)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input int a_w, input logic [DATA_W-1:0] d,
                         input int a1, input int a2, input int ad);
        rst      = r;
        we       = w;
        wa       = ADDR_W'(a_w);
        wd       = d;
        ra1      = ADDR_W'(a1);
        ra2      = ADDR_W'(a2);
        dbg_addr = ADDR_W'(ad);
    endtask

    task automatic push(input int tag, input logic [DATA_W-1:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    // Tags 0..2: write-through rd1/rd2/dbg; tags 3..5: no-write-through rd1/rd2/dbg.
    task automatic expect_split(input logic [DATA_W-1:0] w1, input logic [DATA_W-1:0] w2,
                                input logic [DATA_W-1:0] n1, input logic [DATA_W-1:0] n2,
                                input logic [DATA_W-1:0] dv);
        push(0, w1); push(1, w2); push(2, dv);
        push(3, n1); push(4, n2); push(5, dv);
    endtask

    task automatic expect_all(input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2,
                              input logic [DATA_W-1:0] ed);
        expect_split(e1, e2, e1, e2, ed);
    endtask

    // Monitor / scoreboard: outputs are combinational, so they are valid mid-cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            int                tag;
            logic [DATA_W-1:0] exp_v;
            logic [DATA_W-1:0] act;
            string             name;
            tag   = tag_q.pop_front();
            exp_v = exp_q.pop_front();
            case (tag)
                0:       begin act = wt_rd1; name = "wt_rd1"; end
                1:       begin act = wt_rd2; name = "wt_rd2"; end
                2:       begin act = wt_dbg; name = "wt_dbg"; end
                3:       begin act = nw_rd1; name = "nw_rd1"; end
                4:       begin act = nw_rd2; name = "nw_rd2"; end
                default: begin act = nw_dbg; name = "nw_dbg"; end
            endcase
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL %s t=%0t ra1=%0d ra2=%0d dbg=%0d got=%h exp=%h",
                         name, $time, ra1, ra2, dbg_addr, act, exp_v);
            end
        end
    end

    initial begin
        logic [DATA_W-1:0] v;

        // Reset for one edge
        drive(1'b1, 1'b0, 0, '0, 0, 0, 0);
        step();

        // 1: every address reads zero after reset
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 0, '0, i, 31 - i, i);
            expect_all('0, '0, '0);
            step();
        end

        // 2: simple write and read back
        drive(1'b0, 1'b1, 5, 32'hDEADBEEF, 0, 0, 0);
        step();
        drive(1'b0, 1'b0, 0, '0, 5, 6, 5);
        expect_all(32'hDEADBEEF, 32'h0, 32'hDEADBEEF);
        step();

        // 3: write to r0 discarded, no bypass of r0 during the write
        drive(1'b0, 1'b1, 0, 32'hFFFFFFFF, 0, 0, 0);
        expect_all('0, '0, '0);
        step();
        drive(1'b0, 1'b0, 0, '0, 0, 5, 0);
        expect_all('0, 32'hDEADBEEF, '0);
        step();

        // 4/5: bypass on both ports vs. stored value
        drive(1'b0, 1'b1, 7, 32'h11, 0, 0, 0);
        step();
        drive(1'b0, 1'b1, 7, 32'h22, 7, 7, 7);
        expect_split(32'h22, 32'h22, 32'h11, 32'h11, 32'h11);
        step();
        drive(1'b0, 1'b0, 0, '0, 7, 7, 7);
        expect_all(32'h22, 32'h22, 32'h22);
        step();

        // Independent bypass: only rd1 hits the write address
        drive(1'b0, 1'b1, 9, 32'h99, 9, 7, 9);
        expect_split(32'h99, 32'h22, 32'h0, 32'h22, 32'h0);
        step();
        drive(1'b0, 1'b0, 0, '0, 9, 7, 9);
        expect_all(32'h99, 32'h22, 32'h99);
        step();

        // 6: fill, then check every register
        for (int i = 1; i < 32; i++) begin
            v = 32'(i) * 32'h01010101;
            drive(1'b0, 1'b1, i, v, 0, 0, 0);
            step();
        end
        for (int i = 1; i < 32; i++) begin
            v = 32'(i) * 32'h01010101;
            drive(1'b0, 1'b0, 0, '0, i, i, i);
            expect_all(v, v, v);
            step();
        end

        // Reset with a concurrent write: stored values shown, no bypass, write dropped
        drive(1'b1, 1'b1, 3, 32'hAAAA, 3, 3, 3);
        expect_all(32'h03030303, 32'h03030303, 32'h03030303);
        step();
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 0, '0, i, 31 - i, i);
            expect_all('0, '0, '0);
            step();
        end

        // Normal operation resumes after reset
        drive(1'b0, 1'b1, 3, 32'h55, 0, 0, 0);
        step();
        drive(1'b0, 1'b0, 0, '0, 3, 4, 3);
        expect_all(32'h55, 32'h0, 32'h55);
        step();

        step();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
